// File: rtl/counter_wrap_monitor.sv
// counter_wrap_monitor: observes a 4-bit enable counter. It counts 15->0 wraps
// into a saturating register, pulses on overflow-flag rising edges, and every
// REPORT_EVERY wraps offers a wrap-count snapshot over a four-phase req/ack
// handshake.
//
// Ports:
//   clk           rising-edge clock shared with the counter
//   reset         asynchronous active-low reset, clears all state
//   clear         synchronous statistics clear (wrap_count, tally, stickies)
//   counter_in    sampled counter value
//   overflow_in   sampled counter overflow flag
//   rpt_ack       consumer acknowledge
//   wrap_count    saturating wrap count
//   ovf_pulse     one-cycle pulse after an overflow_in rise
//   overflow_seen sticky overflow indicator
//   rpt_req       report request
//   rpt_data      wrap_count snapshot, stable while rpt_req is high
//   rpt_missed    sticky, a report threshold hit while the handshake was busy
module counter_wrap_monitor #(
    parameter int unsigned WRAP_W       = 8,
    parameter int unsigned REPORT_EVERY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [3:0]        counter_in,
    input  logic              overflow_in,
    input  logic              rpt_ack,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              ovf_pulse,
    output logic              overflow_seen,
    output logic              rpt_req,
    output logic [WRAP_W-1:0] rpt_data,
    output logic              rpt_missed
);

    localparam int unsigned TALLY_W = ($clog2(REPORT_EVERY) > 0) ? $clog2(REPORT_EVERY) : 1;
    localparam logic [TALLY_W-1:0] TALLY_LAST = TALLY_W'(REPORT_EVERY - 1);
    localparam logic [WRAP_W-1:0]  WRAP_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } state_t;

    state_t             state, state_d;
    logic               run_q;
    logic [3:0]         prev_cnt;
    logic               prev_ovf;
    logic [TALLY_W-1:0] tally;
    logic               wrap_ev;
    logic               thresh;
    logic [WRAP_W-1:0]  wrap_inc;
    logic               rpt_req_d;
    logic [WRAP_W-1:0]  rpt_data_d;
    logic               rpt_missed_d;

    // Wrap detection; clear discards a coincident wrap so it never reaches a threshold.
    always_comb begin
        wrap_ev  = (prev_cnt == 4'hF) && (counter_in == 4'h0);
        wrap_inc = (wrap_count == WRAP_MAX) ? wrap_count : wrap_count + WRAP_W'(1);
        thresh   = wrap_ev && !clear && (tally == TALLY_LAST);
    end

    // Handshake next-state and registered-output next values.
    always_comb begin
        state_d      = state;
        rpt_req_d    = rpt_req;
        rpt_data_d   = rpt_data;
        rpt_missed_d = clear ? 1'b0 : rpt_missed;
        case (state)
            IDLE: begin
                if (thresh) begin
                    rpt_req_d  = 1'b1;
                    rpt_data_d = wrap_inc;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (thresh) rpt_missed_d = 1'b1;
                if (rpt_ack) begin
                    rpt_req_d = 1'b0;
                    state_d   = ACK_LOW;
                end
            end
            ACK_LOW: begin
                if (thresh) rpt_missed_d = 1'b1;
                if (!rpt_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // run_q delays the first update to the second edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            state      <= IDLE;
            rpt_req    <= 1'b0;
            rpt_data   <= '0;
            rpt_missed <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                state      <= state_d;
                rpt_req    <= rpt_req_d;
                rpt_data   <= rpt_data_d;
                rpt_missed <= rpt_missed_d;
            end
        end
    end

    // Sampling history and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_cnt      <= 4'h0;
            prev_ovf      <= 1'b0;
            tally         <= '0;
            wrap_count    <= '0;
            ovf_pulse     <= 1'b0;
            overflow_seen <= 1'b0;
        end else if (run_q) begin
            prev_cnt  <= counter_in;
            prev_ovf  <= overflow_in;
            ovf_pulse <= overflow_in && !prev_ovf;
            if (clear) begin
                tally         <= '0;
                wrap_count    <= '0;
                overflow_seen <= 1'b0;
            end else begin
                if (overflow_in) overflow_seen <= 1'b1;
                if (wrap_ev) begin
                    wrap_count <= wrap_inc;
                    tally      <= (tally == TALLY_LAST) ? '0 : tally + TALLY_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Directed bench for counter_wrap_monitor: instance a uses the defaults
// (WRAP_W=8, REPORT_EVERY=4), instance b uses WRAP_W=4, REPORT_EVERY=1.
module tb_counter_wrap_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_clear, a_ovf, a_ack;
    logic [3:0] a_cnt;
    logic [7:0] a_wrap_count, a_rpt_data;
    logic       a_ovf_pulse, a_overflow_seen, a_rpt_req, a_rpt_missed;
    logic       b_clear, b_ovf, b_ack;
    logic [3:0] b_cnt;
    logic [3:0] b_wrap_count, b_rpt_data;
    logic       b_ovf_pulse, b_overflow_seen, b_rpt_req, b_rpt_missed;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_wrap_monitor #(.WRAP_W(8), .REPORT_EVERY(4)) u_a (
        .clk(clk), .reset(reset), .clear(a_clear), .counter_in(a_cnt),
        .overflow_in(a_ovf), .rpt_ack(a_ack), .wrap_count(a_wrap_count),
        .ovf_pulse(a_ovf_pulse), .overflow_seen(a_overflow_seen),
        .rpt_req(a_rpt_req), .rpt_data(a_rpt_data), .rpt_missed(a_rpt_missed)
    );

    counter_wrap_monitor #(.WRAP_W(4), .REPORT_EVERY(1)) u_b (
        .clk(clk), .reset(reset), .clear(b_clear), .counter_in(b_cnt),
        .overflow_in(b_ovf), .rpt_ack(b_ack), .wrap_count(b_wrap_count),
        .ovf_pulse(b_ovf_pulse), .overflow_seen(b_overflow_seen),
        .rpt_req(b_rpt_req), .rpt_data(b_rpt_data), .rpt_missed(b_rpt_missed)
    );

    // Advance one edge; outputs are then stable and new inputs apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive counter 1..15 on instance a, leaving 0 for the caller's wrap edge.
    task automatic run_to_f_a();
        for (int v = 1; v <= 15; v++) begin
            a_cnt = 4'(v);
            tick();
        end
    endtask

    task automatic wrap_a();
        run_to_f_a();
        a_cnt = 4'h0;
        tick();
    endtask

    task automatic wrap_b();
        for (int v = 1; v <= 15; v++) begin
            b_cnt = 4'(v);
            tick();
        end
        b_cnt = 4'h0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; a_cnt = 4'hF; a_ovf = 1'b1; a_ack = 1'b0; a_clear = 1'b0;
        b_cnt = 4'h0; b_ovf = 1'b0; b_ack = 1'b0; b_clear = 1'b0;
        tick(); tick();
        checks++; if ({a_wrap_count, a_rpt_data} !== 16'h0) begin failures++; $display("FAIL reset_counts got=%0h exp=0", {a_wrap_count, a_rpt_data}); end
        checks++; if ({a_ovf_pulse, a_overflow_seen, a_rpt_req, a_rpt_missed} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {a_ovf_pulse, a_overflow_seen, a_rpt_req, a_rpt_missed}); end
        reset = 1'b1; a_cnt = 4'h0;
        tick();
        checks++; if (a_ovf_pulse !== 1'b0) begin failures++; $display("FAIL release_edge1_pulse got=%b exp=0", a_ovf_pulse); end
        tick();
        checks++; if (a_ovf_pulse !== 1'b1) begin failures++; $display("FAIL release_pulse got=%b exp=1", a_ovf_pulse); end
        checks++; if (a_overflow_seen !== 1'b1) begin failures++; $display("FAIL release_ovf_seen got=%b exp=1", a_overflow_seen); end
        tick();
        checks++; if (a_ovf_pulse !== 1'b0) begin failures++; $display("FAIL pulse_one_cycle got=%b exp=0", a_ovf_pulse); end
        checks++; if (a_wrap_count !== 8'd0) begin failures++; $display("FAIL release_no_wrap got=%0d exp=0", a_wrap_count); end
        a_ovf = 1'b0;
        tick();
    endtask

    task automatic test_report();
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        for (int i = 0; i < 3; i++) wrap_a();
        checks++; if (a_wrap_count !== 8'd3) begin failures++; $display("FAIL wrap3_count got=%0d exp=3", a_wrap_count); end
        checks++; if (a_rpt_req !== 1'b0) begin failures++; $display("FAIL wrap3_req got=%b exp=0", a_rpt_req); end
        wrap_a();
        checks++; if (a_wrap_count !== 8'd4) begin failures++; $display("FAIL wrap4_count got=%0d exp=4", a_wrap_count); end
        checks++; if (a_rpt_req !== 1'b1) begin failures++; $display("FAIL wrap4_req got=%b exp=1", a_rpt_req); end
        checks++; if (a_rpt_data !== 8'd4) begin failures++; $display("FAIL wrap4_data got=%0d exp=4", a_rpt_data); end
        tick(); tick();
        checks++; if (a_rpt_req !== 1'b1) begin failures++; $display("FAIL req_hold got=%b exp=1", a_rpt_req); end
        a_ack = 1'b1;
        tick();
        checks++; if (a_rpt_req !== 1'b0) begin failures++; $display("FAIL req_fall got=%b exp=0", a_rpt_req); end
        checks++; if (a_rpt_data !== 8'd4) begin failures++; $display("FAIL data_after_ack got=%0d exp=4", a_rpt_data); end
        a_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) wrap_a();
        checks++; if (a_rpt_req !== 1'b1) begin failures++; $display("FAIL wrap8_req got=%b exp=1", a_rpt_req); end
        checks++; if (a_rpt_data !== 8'd8) begin failures++; $display("FAIL wrap8_data got=%0d exp=8", a_rpt_data); end
        checks++; if (a_rpt_missed !== 1'b0) begin failures++; $display("FAIL wrap8_missed got=%b exp=0", a_rpt_missed); end
        a_ack = 1'b1; tick(); a_ack = 1'b0; tick();
    endtask

    task automatic test_missed();
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        for (int i = 0; i < 7; i++) wrap_a();
        checks++; if (a_rpt_missed !== 1'b0) begin failures++; $display("FAIL missed_early got=%b exp=0", a_rpt_missed); end
        wrap_a();
        checks++; if (a_rpt_missed !== 1'b1) begin failures++; $display("FAIL missed_set got=%b exp=1", a_rpt_missed); end
        checks++; if (a_rpt_req !== 1'b1) begin failures++; $display("FAIL missed_req got=%b exp=1", a_rpt_req); end
        checks++; if (a_rpt_data !== 8'd4) begin failures++; $display("FAIL missed_data got=%0d exp=4", a_rpt_data); end
        checks++; if (a_wrap_count !== 8'd8) begin failures++; $display("FAIL missed_count got=%0d exp=8", a_wrap_count); end
    endtask

    task automatic test_clear();
        a_ovf = 1'b1; tick(); a_ovf = 1'b0;
        checks++; if (a_overflow_seen !== 1'b1) begin failures++; $display("FAIL clear_pre_seen got=%b exp=1", a_overflow_seen); end
        run_to_f_a();
        a_cnt = 4'h0; a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        checks++; if (a_wrap_count !== 8'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", a_wrap_count); end
        checks++; if ({a_overflow_seen, a_rpt_missed} !== 2'b00) begin failures++; $display("FAIL clear_sticky got=%b exp=00", {a_overflow_seen, a_rpt_missed}); end
        checks++; if ({a_rpt_req, a_rpt_data} !== {1'b1, 8'd4}) begin failures++; $display("FAIL clear_keeps_req got=%0h exp=104", {a_rpt_req, a_rpt_data}); end
        wrap_a();
        checks++; if (a_wrap_count !== 8'd1) begin failures++; $display("FAIL post_clear_count got=%0d exp=1", a_wrap_count); end
    endtask

    task automatic test_async_reset();
        #3 reset = 1'b0;
        #1;
        checks++; if ({a_rpt_req, a_rpt_data, a_wrap_count} !== 17'h0) begin failures++; $display("FAIL async_reset got=%0h exp=0", {a_rpt_req, a_rpt_data, a_wrap_count}); end
        a_cnt = 4'h0; a_ack = 1'b0; a_clear = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) wrap_a();
        checks++; if ({a_rpt_req, a_rpt_data} !== {1'b1, 8'd4}) begin failures++; $display("FAIL post_reset_report got=%0h exp=104", {a_rpt_req, a_rpt_data}); end
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 20; i++) begin
            wrap_b();
            checks++; if ({b_rpt_req, b_rpt_data} !== {1'b1, 4'((i > 15) ? 15 : i)}) begin failures++; $display("FAIL sat_report%0d got=%0h exp=%0h", i, {b_rpt_req, b_rpt_data}, {1'b1, 4'((i > 15) ? 15 : i)}); end
            b_ack = 1'b1; tick(); b_ack = 1'b0; tick();
        end
        checks++; if (b_wrap_count !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", b_wrap_count); end
        for (int v = 1; v <= 15; v++) begin
            b_cnt = 4'(v);
            tick();
        end
        b_cnt = 4'h5; tick();
        b_cnt = 4'h0; tick(); tick();
        checks++; if ({b_rpt_req, b_rpt_missed} !== 2'b00) begin failures++; $display("FAIL non_wrap_ignored got=%b exp=00", {b_rpt_req, b_rpt_missed}); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_report();
        test_missed();
        test_clear();
        test_async_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_wrap_monitor.md
# counter_wrap_monitor

Downstream observer for the 4-bit enable counter. It samples the counter value and overflow flag every clock, counts wrap-arounds (15→0) into a wider saturating register and detects overflow-flag rising edges. Every REPORT_EVERY wraps it offers a snapshot of the wrap count to a slow consumer over a four-phase req/ack handshake. It sits directly after the counter and feeds status/interrupt logic.

## Interface
- WRAP_W, default 8: width of wrap count and report data.
- REPORT_EVERY, default 4: wraps per report; legal range 1..2^WRAP_W-1.

- clk  in  1  rising-edge clock shared with the counter.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- clear  in  1  synchronous clear of statistics, active high.
- counter_in  in  4  counter value, changes after clk rising edges.
- overflow_in  in  1  counter overflow flag, level or pulse.
- rpt_ack  in  1  consumer acknowledge, four-phase.
- wrap_count  out  WRAP_W  saturating count of detected wraps.
- ovf_pulse  out  1  one-cycle pulse on overflow_in rising edge.
- overflow_seen  out  1  sticky, set once overflow_in is sampled high.
- rpt_req  out  1  report request.
- rpt_data  out  WRAP_W  wrap_count snapshot, stable while rpt_req is high.
- rpt_missed  out  1  sticky, a report threshold hit while the handshake was busy.

## Operation
- Registers: prev_cnt[3:0], prev_ovf, tally (0..REPORT_EVERY-1), FSM state, plus every output. All reset to 0. FSM resets to IDLE.
- Every edge: prev_cnt <= counter_in and prev_ovf <= overflow_in. clear does not affect these.
- Wrap event at an edge: prev_cnt == 4'hF and counter_in == 4'h0. Any other transition is ignored, including 15→non-zero, 0→0, and the first 0 after reset.
- On a wrap event:
  - wrap_count increments and saturates at 2^WRAP_W-1.
  - tally increments. At REPORT_EVERY-1 it returns to 0 and raises a threshold event. Tally and thresholds continue after saturation.
- ovf_pulse is registered: 1 for exactly one cycle when overflow_in == 1 and prev_ovf == 0.
- overflow_seen is set when overflow_in is sampled at 1. It holds until clear or reset.
- Handshake FSM (IDLE, REQ, ACK_LOW):
  - IDLE + threshold: rpt_data <= post-increment wrap_count (saturated value if saturated), rpt_req <= 1, go to REQ.
  - REQ: rpt_req and rpt_data hold. On rpt_ack == 1, rpt_req <= 0 and go to ACK_LOW.
  - ACK_LOW: on rpt_ack == 0, go to IDLE.
  - A threshold in REQ or ACK_LOW, including the edge leaving ACK_LOW, sets rpt_missed. rpt_data is not overwritten.
- clear:
  - Zeroes wrap_count, tally, overflow_seen and rpt_missed.
  - Wins over a simultaneous wrap or overflow at the same edge; that event is discarded.
  - Does not touch the FSM, rpt_req, rpt_data, ovf_pulse, prev_cnt or prev_ovf.
- Reset low mid-operation: all outputs go to 0 immediately, and any in-flight handshake is abandoned.

## Timing
- Wrap latency: wrap_count updates at the same edge that samples counter_in == 0 after 15. It is visible 1 cycle after the counter shows 0.
- rpt_req rises at that same edge when a threshold hits in IDLE.
- rpt_req falls at the first edge that samples rpt_ack == 1.
- The next rpt_req can rise no earlier than 1 edge after the edge that samples rpt_ack == 0.
- ovf_pulse is high for the cycle after the edge that samples the overflow_in rise.
- Reset assertion is asynchronous. Release is sampled at the next rising clk; first update happens on the second edge after release.
- No combinational input→output paths.

## Test plan
- Hold reset low with counter_in = F and overflow_in = 1, then release and drive counter_in = 0 → all outputs 0 during reset; ovf_pulse = 1 for 1 cycle after release; no wrap counted.
- Count 0..15 repeatedly for 4 wraps, REPORT_EVERY = 4 → wrap_count = 4; rpt_req rises with rpt_data = 4 on the 4th wrap edge. Raise rpt_ack 3 cycles later → rpt_req low next edge. Drop rpt_ack → IDLE. 8th wrap → rpt_data = 8.
- Keep rpt_ack = 0 for 8 wraps → rpt_req stays 1, rpt_data stays 4, rpt_missed = 1 after the 8th wrap, wrap_count = 8.
- WRAP_W = 4, REPORT_EVERY = 1, ack every request, 20 wraps → wrap_count saturates at 15; later reports carry 15; sequence F→5 and 0→0 add nothing.
- Assert clear at the same edge as a wrap, with overflow_seen = 1 and rpt_missed = 1 → wrap_count = 0, overflow_seen = 0, rpt_missed = 0. rpt_req state is unchanged.
- Pull reset low between clock edges while rpt_req = 1 → rpt_req and rpt_data go to 0 immediately. After release, a full 4-wrap sequence yields rpt_data = 4.
